carrier_gen_nch: RTL

//  Multi-channel, width-parametrised PWM carrier generator with per-channel phase offsets.

---
 rtl/carrier_gen_nch.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/carrier_gen_nch.sv
// Multi-channel PWM carrier generator (up / down / up-down) with per-channel phase
// offsets and double-buffered period/mode. Optional resync port pair: CARR_SYNC_EN.
module carrier_gen_nch #(
   parameter int CW  = 16,
   parameter int NCH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          count_mode,
   input  logic [CW-1:0]       period,
   input  logic [NCH*CW-1:0]   phase,
   input  logic                upd_req,
`ifdef CARR_SYNC_EN
   input  logic                sync_in,
   output logic                sync_out,
`endif
   output logic [NCH*CW-1:0]   carrier,
   output logic [NCH-1:0]      dir,
   output logic [NCH-1:0]      zero_evt,
   output logic [NCH-1:0]      peak_evt,
   output logic                upd_pend
);

   // state | meaning
   // IDLE  | stopped, carriers 0, shadow follows period/count_mode
   // LOAD  | one cycle: shadow -> active, channels take clipped phase
   // RUN   | carriers counting, updates applied at ch0 zero
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   localparam logic [1:0] COUNT_UP     = 2'd0;
   localparam logic [1:0] COUNT_DOWN   = 2'd1;
   localparam logic [1:0] COUNT_UPDOWN = 2'd2;

   state_t            state_q, state_d;
   logic [CW-1:0]     carr_q [NCH];
   logic [CW-1:0]     carr_d [NCH];
   logic [NCH-1:0]    dir_q, dir_d;
   logic [CW-1:0]     act_p_q, act_p_d, sh_p_q, sh_p_d;
   logic [1:0]        act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
   logic              upd_pend_q, upd_pend_d;
   logic              run;
   logic              apply;
   logic [CW-1:0]     p_eff;
   logic [1:0]        m_eff;

   assign run      = (state_q == S_RUN);
   assign upd_pend = upd_pend_q;
   assign dir      = dir_q;
   assign apply    = run && upd_pend_q && zero_evt[0];
   assign p_eff    = apply ? sh_p_q : act_p_q;
   assign m_eff    = apply ? sh_mode_q : act_mode_q;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         carrier[k*CW +: CW] = carr_q[k];
         zero_evt[k]         = run && (carr_q[k] == '0);
         peak_evt[k]         = run && (carr_q[k] == act_p_q);
      end
   end

   always_comb begin
      logic [CW-1:0] ph;
      logic [CW-1:0] c;
      logic [CW-1:0] nc;
      logic          nd;
      logic          resync;
      ph         = '0;
      c          = '0;
      nc         = '0;
      nd         = 1'b0;
      resync     = 1'b0;
      state_d    = state_q;
      carr_d     = carr_q;
      dir_d      = dir_q;
      act_p_d    = act_p_q;
      act_mode_d = act_mode_q;
      sh_p_d     = sh_p_q;
      sh_mode_d  = sh_mode_q;
      upd_pend_d = upd_pend_q;
`ifdef CARR_SYNC_EN
      resync     = sync_in;
`endif
      case (state_q)
         S_IDLE: begin
            sh_p_d    = period;
            sh_mode_d = count_mode;
            for (int k = 0; k < NCH; k++) carr_d[k] = '0;
            dir_d     = '0;
            if (enable && (period != '0)) state_d = S_LOAD;
         end
         S_LOAD: begin
            act_p_d    = sh_p_q;
            act_mode_d = sh_mode_q;
            upd_pend_d = 1'b0;
            for (int k = 0; k < NCH; k++) begin
               ph        = phase[k*CW +: CW];
               carr_d[k] = (ph > sh_p_q) ? sh_p_q : ph;
               dir_d[k]  = (sh_mode_q == COUNT_DOWN);
            end
            state_d = S_RUN;
         end
         S_RUN: begin
            if (!enable || (act_p_q == '0)) begin
               state_d = S_IDLE;
               for (int k = 0; k < NCH; k++) carr_d[k] = '0;
               dir_d   = '0;
            end else begin
               if (apply) begin
                  act_p_d    = sh_p_q;
                  act_mode_d = sh_mode_q;
                  upd_pend_d = 1'b0;
               end
               // a request landing on the apply cycle waits for the next ch0 zero
               if (upd_req) begin
                  sh_p_d     = period;
                  sh_mode_d  = count_mode;
                  upd_pend_d = 1'b1;
               end
               for (int k = 0; k < NCH; k++) begin
                  c = carr_q[k];
                  if (resync) begin
                     ph = phase[k*CW +: CW];
                     nc = (ph > p_eff) ? p_eff : ph;
                     nd = (m_eff == COUNT_DOWN);
                  end else begin
                     case (m_eff)
                        COUNT_DOWN: begin
                           nd = 1'b1;
                           nc = (c > '0) ? c - 1'b1 : p_eff;
                        end
                        COUNT_UPDOWN: begin
                           if (!dir_q[k]) begin
                              if (c < p_eff) begin nc = c + 1'b1; nd = 1'b0; end
                              else           begin nc = c - 1'b1; nd = 1'b1; end
                           end else begin
                              if (c > '0) begin nc = c - 1'b1; nd = 1'b1; end
                              else        begin nc = c + 1'b1; nd = 1'b0; end
                           end
                        end
                        default: begin
                           nd = 1'b0;
                           nc = (c < p_eff) ? c + 1'b1 : '0;
                        end
                     endcase
                     // a shrunk period can leave a channel beyond the new peak
                     if (nc > p_eff) begin
                        if (m_eff == COUNT_DOWN || m_eff == COUNT_UPDOWN) begin
                           nc = p_eff;
                           nd = 1'b1;
                        end else begin
                           nc = '0;
                        end
                     end
                  end
                  carr_d[k] = nc;
                  dir_d[k]  = nd;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         for (int k = 0; k < NCH; k++) carr_q[k] <= '0;
         dir_q      <= '0;
         act_p_q    <= '0;
         act_mode_q <= COUNT_UP;
         sh_p_q     <= '0;
         sh_mode_q  <= COUNT_UP;
         upd_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         carr_q     <= carr_d;
         dir_q      <= dir_d;
         act_p_q    <= act_p_d;
         act_mode_q <= act_mode_d;
         sh_p_q     <= sh_p_d;
         sh_mode_q  <= sh_mode_d;
         upd_pend_q <= upd_pend_d;
      end
   end

`ifdef CARR_SYNC_EN
   logic sync_out_q, sync_out_d;
   assign sync_out_d = zero_evt[0];
   assign sync_out   = sync_out_q;
   always_ff @(posedge clk) begin
      if (reset) sync_out_q <= 1'b0;
      else       sync_out_q <= sync_out_d;
   end
`endif

endmodule
